// File: rtl/jh_power_pkg.sv
// Shared types and constants for the jh_power PWM power stage.
package jh_power_pkg;

    localparam int unsigned LEVEL_W = 6;
    localparam int unsigned SLOTS   = 63;
    localparam logic [LEVEL_W-1:0] DEFAULT_CAP = 6'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Requested level limited to the active ceiling.
    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl,
                                                       input logic [LEVEL_W-1:0] cap);
        return (lvl < cap) ? lvl : cap;
    endfunction

endpackage

// File: rtl/jh_pwm_timebase.sv
// Prescaler plus 63-slot counter; one PWM period is SLOTS*PRESCALE cycles.
module jh_pwm_timebase
    import jh_power_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    output logic [LEVEL_W-1:0] slot,
    output logic               period_end
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [LEVEL_W-1:0] SLOT_LAST = LEVEL_W'(SLOTS - 1);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [LEVEL_W-1:0] slot_q, slot_d;
    logic               pre_wrap;

    assign pre_wrap = (pre_q == PRE_LAST);

    always_comb begin
        pre_d  = pre_q;
        slot_d = slot_q;
        if (!run) begin
            pre_d  = '0;
            slot_d = '0;
        end else if (pre_wrap) begin
            pre_d  = '0;
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 6'd1;
        end else begin
            pre_d  = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q  <= '0;
            slot_q <= '0;
        end else begin
            pre_q  <= pre_d;
            slot_q <= slot_d;
        end
    end

    assign slot       = slot_q;
    assign period_end = pre_wrap && (slot_q == SLOT_LAST);

endmodule

// File: rtl/jh_power_pwm.sv
// Slot-based PWM power stage with soft-start ramp, level clamp and sticky fault lockout.
module jh_power_pwm
    import jh_power_pkg::*;
#(
    parameter int unsigned PRESCALE  = 16,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic [LEVEL_W-1:0] max_power,
    input  logic               power_unlock,
    input  logic               i_fault,
    output logic               o_drive,
    output logic               o_period_done,
    output logic [LEVEL_W-1:0] o_active_level,
    output logic [1:0]         o_state
);

    localparam int unsigned SUM_W = LEVEL_W + 1;

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] active_q, active_d;
    logic               drive_q, drive_d;
    logic [LEVEL_W-1:0] slot;
    logic               period_end;
    logic               run;
    logic               running_q, running_d;
    logic               keep_running;
    logic [LEVEL_W-1:0] cap, target;
    logic [SUM_W-1:0]   ramp_sum;
    logic               ramp_done;

    assign cap       = power_unlock ? max_power : DEFAULT_CAP;
    assign target    = clamp_level(i_level, cap);
    assign ramp_sum  = {1'b0, active_q} + SUM_W'(RAMP_STEP);
    assign ramp_done = ({1'b0, target} <= ramp_sum);

    assign running_q    = (state_q == ST_RAMP) || (state_q == ST_RUN);
    assign running_d    = (state_d == ST_RAMP) || (state_d == ST_RUN);
    assign keep_running = running_q && enable && !i_fault;
    // Counters start from 0 on the first RAMP cycle and clear on the edge that leaves RAMP/RUN.
    assign run          = running_q && running_d;

    jh_pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .slot       (slot),
        .period_end (period_end)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Priority: fault, then enable drop, then the period-end update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable && !i_fault) state_d = ST_RAMP;
            ST_RAMP,
            ST_RUN: begin
                if (i_fault)      state_d = ST_FAULT;
                else if (!enable) state_d = ST_IDLE;
                else if (period_end && (state_q == ST_RAMP) && ramp_done) state_d = ST_RUN;
            end
            ST_FAULT: if (!enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        active_d = '0;
        drive_d  = 1'b0;
        if (keep_running) begin
            drive_d  = (slot < active_q);
            active_d = active_q;
            if (period_end) begin
                active_d = ((state_q == ST_RAMP) && !ramp_done) ? ramp_sum[LEVEL_W-1:0] : target;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q <= '0;
            drive_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            drive_q  <= drive_d;
        end
    end

    assign o_drive        = drive_q;
    assign o_active_level = active_q;
    assign o_state        = state_q;
    assign o_period_done  = keep_running && period_end && !reset;

endmodule

// File: tb/tb_jh_power_pwm.sv
// Directed plus randomized bench for jh_power_pwm against a cycle-phase reference model.
module tb_jh_power_pwm;

    localparam int unsigned P    = 2;
    localparam int unsigned STEP = 1;
    localparam int unsigned PER  = 63 * P;

    logic       clock = 1'b0;
    logic       reset, enable, power_unlock, i_fault;
    logic [5:0] i_level, max_power;
    logic       o_drive, o_period_done;
    logic [5:0] o_active_level;
    logic [1:0] o_state;

    jh_power_pwm #(
        .PRESCALE  (P),
        .RAMP_STEP (STEP)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .i_level        (i_level),
        .max_power      (max_power),
        .power_unlock   (power_unlock),
        .i_fault        (i_fault),
        .o_drive        (o_drive),
        .o_period_done  (o_period_done),
        .o_active_level (o_active_level),
        .o_state        (o_state)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0..3, applied level, cycles since entering RAMP, registered drive.
    int m_st  = 0;
    int m_lvl = 0;
    int m_k   = 0;
    bit m_drive = 1'b0;

    bit last_done, last_drive;
    int cnt_done, cnt_drive, last_pulse_cyc, cyc;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int target_level();
        int cap;
        cap = power_unlock ? int'(max_power) : 31;
        return (int'(i_level) < cap) ? int'(i_level) : cap;
    endfunction

    task automatic model_step();
        int t;
        if (reset) begin
            m_st = 0; m_lvl = 0; m_k = 0; m_drive = 1'b0;
        end else begin
            case (m_st)
                0: begin
                    m_drive = 1'b0;
                    if (enable && !i_fault) begin m_st = 1; m_lvl = 0; m_k = 0; end
                end
                1, 2: begin
                    if (i_fault) begin
                        m_st = 3; m_lvl = 0; m_drive = 1'b0;
                    end else if (!enable) begin
                        m_st = 0; m_lvl = 0; m_drive = 1'b0;
                    end else begin
                        m_drive = ((m_k % PER) / P) < m_lvl;
                        if ((m_k % PER) == PER - 1) begin
                            t = target_level();
                            if (m_st == 1 && t > m_lvl + int'(STEP)) m_lvl = m_lvl + int'(STEP);
                            else begin m_lvl = t; m_st = 2; end
                        end
                        m_k++;
                    end
                end
                default: begin
                    m_drive = 1'b0;
                    m_lvl = 0;
                    if (!enable) m_st = 0;
                end
            endcase
        end
    endtask

    // One clock: check all outputs before the edge, advance the model on the edge.
    task automatic tick();
        bit exp_done;
        #1;
        exp_done = !reset && (m_st == 1 || m_st == 2) && enable && !i_fault
                   && ((m_k % PER) == PER - 1);
        chk("state", 8'(o_state), 8'(m_st));
        chk("level", 8'(o_active_level), 8'(m_lvl));
        chk("drive", 8'(o_drive), 8'(m_drive));
        chk("period_done", 8'(o_period_done), 8'(exp_done));
        last_done  = o_period_done;
        last_drive = o_drive;
        @(posedge clock);
        model_step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_ticks(input int n);
        cnt_done  = 0;
        cnt_drive = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            cnt_done  += int'(last_done);
            cnt_drive += int'(last_drive);
        end
    endtask

    // Bounded wait until the next cycle sits at the given period phase while running.
    task automatic wait_phase(input int ph, input string tag);
        int n;
        n = 0;
        while (!((m_st == 1 || m_st == 2) && (m_k % PER) == ph) && n < 3 * PER) begin
            tick();
            n++;
        end
        chk(tag, 8'((n < 3 * PER) ? 1 : 0), 8'd1);
    endtask

    initial begin
        int pulses, gap_ok, n;
        reset = 1'b1; enable = 1'b1; i_fault = 1'b0; power_unlock = 1'b0;
        i_level = 6'd10; max_power = 6'd0; cyc = 0;
        @(negedge clock);

        // Reset held with enable high.
        run_ticks(3);
        reset = 1'b0;
        tick();
        chk("post_reset_state", 8'(o_state), 8'd1);

        // Ramp to 10, one step per period.
        pulses = 0; gap_ok = 1; last_pulse_cyc = -1; n = 0;
        while (o_state !== 2'd2 && n < 12 * PER) begin
            tick();
            n++;
            if (last_done) begin
                pulses++;
                if (last_pulse_cyc >= 0 && (cyc - last_pulse_cyc) != PER) gap_ok = 0;
                last_pulse_cyc = cyc;
                #1 chk("ramp_step_level", 8'(o_active_level), 8'(pulses));
            end
        end
        chk("ramp_pulses", 8'(pulses), 8'd10);
        chk("ramp_gap", 8'(gap_ok), 8'd1);
        run_ticks(PER);
        chk("run_drive_count", 8'(cnt_drive), 8'd20);
        chk("run_done_count", 8'(cnt_done), 8'd1);

        // Clamp behaviour.
        i_level = 6'd50;
        run_ticks(PER + 4);
        chk("clamp_31", 8'(o_active_level), 8'd31);
        power_unlock = 1'b1; max_power = 6'd40;
        run_ticks(PER + 4);
        chk("clamp_40", 8'(o_active_level), 8'd40);
        max_power = 6'd63; i_level = 6'd63;
        run_ticks(PER + 4);
        run_ticks(PER);
        chk("full_on", 8'(cnt_drive), 8'(PER));
        i_level = 6'd0;
        run_ticks(PER + 4);
        run_ticks(PER);
        chk("full_off", 8'(cnt_drive), 8'd0);

        // Fault pulse mid-period.
        i_level = 6'd20; power_unlock = 1'b0;
        run_ticks(PER + 4);
        wait_phase(40, "wait_mid_period");
        i_fault = 1'b1;
        tick();
        i_fault = 1'b0;
        #1 chk("fault_state", 8'(o_state), 8'd3);
        chk("fault_drive", 8'(o_drive), 8'd0);
        run_ticks(2 * PER + 10);
        chk("fault_no_done", 8'(cnt_done), 8'd0);
        chk("fault_sticky", 8'(o_state), 8'd3);
        enable = 1'b0;
        tick();
        #1 chk("fault_exit_idle", 8'(o_state), 8'd0);
        enable = 1'b1;
        tick();
        #1 chk("restart_ramp", 8'(o_state), 8'd1);
        chk("restart_level", 8'(o_active_level), 8'd0);

        // Enable drop on the period-end cycle.
        run_ticks(3 * PER);
        wait_phase(PER - 1, "wait_period_end");
        enable = 1'b0;
        tick();
        chk("drop_no_done", 8'(last_done), 8'd0);
        #1 chk("drop_idle", 8'(o_state), 8'd0);
        chk("drop_level", 8'(o_active_level), 8'd0);

        // Fault and enable drop on the same cycle.
        enable = 1'b1; i_level = 6'd30;
        run_ticks(20);
        i_fault = 1'b1; enable = 1'b0;
        tick();
        #1 chk("simul_fault", 8'(o_state), 8'd3);
        i_fault = 1'b0;
        tick();
        #1 chk("simul_idle", 8'(o_state), 8'd0);

        // Reset mid-ramp at level 5.
        enable = 1'b1;
        n = 0;
        while (m_lvl != 5 && n < 8 * PER) begin tick(); n++; end
        chk("wait_level5", 8'(o_active_level), 8'd5);
        run_ticks(37);
        reset = 1'b1;
        tick();
        tick();
        chk("reset_drive", 8'(o_drive), 8'd0);
        chk("reset_level", 8'(o_active_level), 8'd0);
        chk("reset_state", 8'(o_state), 8'd0);
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            reset   = ($urandom_range(0, 999) < 2);
            enable  = ($urandom_range(0, 999) >= 4);
            i_fault = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 49) == 0)  i_level = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 299) == 0) begin
                power_unlock = 1'($urandom_range(0, 1));
                max_power    = 6'($urandom_range(0, 63));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
